// File: rtl/mips_pkg.sv
// Shared register-file constants and types for the operand-read path.
package mips_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    // Architectural zero register: always reads 0, writes dropped.
    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/reg_storage.sv
// 32 x 32 GPR array: two combinational read ports, one synchronous write port,
// synchronous clear, register 0 masked to zero.
module reg_storage
    import mips_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      we_i,
    input  reg_addr_t waddr_i,
    input  word_t     wdata_i,
    input  reg_addr_t raddr_a_i,
    output word_t     rdata_a_o,
    input  reg_addr_t raddr_b_i,
    output word_t     rdata_b_o
);

    word_t mem_q [DEPTH];
    word_t mem_d [DEPTH];

    // Next-state of the array: write port, with writes to r0 discarded.
    always_comb begin
        mem_d = mem_q;
        if (we_i && (waddr_i != ZERO_REG)) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    // Storage flops with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Combinational reads; r0 forced to zero regardless of flop contents.
    always_comb begin
        rdata_a_o = (raddr_a_i == ZERO_REG) ? '0 : mem_q[raddr_a_i];
        rdata_b_o = (raddr_b_i == ZERO_REG) ? '0 : mem_q[raddr_b_i];
    end

endmodule

// File: rtl/reg_read_port.sv
// Operand-read port of the register file: valid/ready request of Rs/Rt, one-entry
// registered response stage toward ID/EX.
// Optional macro WB_BYPASS_EN: forwards a same-cycle writeback into the accepted
// operands and refreshes held operands during a stall.
module reg_read_port
    import mips_pkg::*;
(
    input  logic      Clk,
    input  logic      Reset,
    input  logic      ReqValid,
    output logic      ReqReady,
    input  reg_addr_t RsAddr,
    input  reg_addr_t RtAddr,
    output logic      RspValid,
    input  logic      RspReady,
    output word_t     RsData,
    output word_t     RtData,
    input  logic      WrEn,
    input  reg_addr_t WrAddr,
    input  word_t     WrData,
    input  logic      Flush
);

    logic  rsp_valid_q, rsp_valid_d;
    word_t rs_data_q, rs_data_d;
    word_t rt_data_q, rt_data_d;
    word_t rs_rd, rt_rd;
    word_t rs_sel, rt_sel;
    logic  accept;
    logic  stall;

    reg_storage u_storage (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .we_i      (WrEn),
        .waddr_i   (WrAddr),
        .wdata_i   (WrData),
        .raddr_a_i (RsAddr),
        .rdata_a_o (rs_rd),
        .raddr_b_i (RtAddr),
        .rdata_b_o (rt_rd)
    );

    assign ReqReady = !rsp_valid_q || RspReady;
    assign accept   = ReqValid && ReqReady && !Flush;
    assign stall    = rsp_valid_q && !RspReady;

`ifdef WB_BYPASS_EN
    reg_addr_t rs_addr_q, rs_addr_d;
    reg_addr_t rt_addr_q, rt_addr_d;
    logic      wr_live;

    assign wr_live = WrEn && (WrAddr != ZERO_REG);

    // Forward the in-flight writeback into the operands being captured.
    always_comb begin
        rs_sel = (wr_live && (WrAddr == RsAddr)) ? WrData : rs_rd;
        rt_sel = (wr_live && (WrAddr == RtAddr)) ? WrData : rt_rd;
    end

    // Remember which registers the held response came from.
    always_comb begin
        rs_addr_d = rs_addr_q;
        rt_addr_d = rt_addr_q;
        if (accept) begin
            rs_addr_d = RsAddr;
            rt_addr_d = RtAddr;
        end
    end

    // Captured-address flops.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rs_addr_q <= '0;
            rt_addr_q <= '0;
        end else begin
            rs_addr_q <= rs_addr_d;
            rt_addr_q <= rt_addr_d;
        end
    end
`else
    // Read-before-write: accepted operands see the pre-write storage value.
    always_comb begin
        rs_sel = rs_rd;
        rt_sel = rt_rd;
    end
`endif

    // Next-state of the response stage: accept, flush, drain, or hold.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rs_data_d   = rs_sel;
            rt_data_d   = rt_sel;
        end else if (Flush) begin
            rsp_valid_d = 1'b0;
        end else if (rsp_valid_q && RspReady) begin
            rsp_valid_d = 1'b0;
        end else if (stall) begin
`ifdef WB_BYPASS_EN
            if (wr_live && (WrAddr == rs_addr_q)) rs_data_d = WrData;
            if (wr_live && (WrAddr == rt_addr_q)) rt_data_d = WrData;
`endif
        end
    end

    // Response-stage flops; reset wins over every other action.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rsp_valid_q <= 1'b0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
        end
    end

    assign RspValid = rsp_valid_q;
    assign RsData   = rs_data_q;
    assign RtData   = rt_data_q;

endmodule
